// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - core request/response and RAM command bundle for mem_access_ctrl

interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction fetch channel
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic              if_err;

    // Load/store channel
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ready;
    logic              ls_valid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    // RAM command and read-back
    logic              mem_enable;
    logic [1:0]        mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_fetch;

    // Controller view: takes core requests and RAM read data, drives everything else
    modport slave (
        input  if_req, if_addr,
        output if_ready, if_valid, if_instr, if_err,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_ready, ls_valid, ls_rdata, ls_err,
        output mem_enable, mem_rw, mem_addr, mem_din,
        input  mem_dout, mem_fetch
    );

    // Environment view: the core plus the RAM
    modport master (
        output if_req, if_addr,
        input  if_ready, if_valid, if_instr, if_err,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_ready, ls_valid, ls_rdata, ls_err,
        input  mem_enable, mem_rw, mem_addr, mem_din,
        output mem_dout, mem_fetch
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - fetch/load-store arbiter and sequencer for the single-port RAM

module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0]        RW_FETCH  = 2'b00;
    localparam logic [1:0]        RW_READ   = 2'b01;
    localparam logic [1:0]        RW_WRITE  = 2'b10;
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    state_t            state_q;
    logic              src_ls_q;   // 1: transaction belongs to load/store, 0: fetch
    logic              we_q;       // transaction is a store

    logic              mem_enable_q;
    logic [1:0]        mem_rw_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;

    logic              if_valid_q;
    logic [DATA_W-1:0] if_instr_q;
    logic              if_err_q;
    logic              ls_valid_q;
    logic [DATA_W-1:0] ls_rdata_q;
    logic              ls_err_q;

    logic              idle;
    logic              ls_accept;
    logic              if_accept;
    logic [ADDR_W-1:0] req_addr_d;
    logic              req_oor_d;

    // Arbitration: load/store wins a same-cycle tie, so the fetch ready drops whenever ls_req is up
    assign idle       = (state_q == IDLE);
    assign ls_accept  = idle & bus.ls_req;
    assign if_accept  = idle & ~bus.ls_req & bus.if_req;
    assign req_addr_d = bus.ls_req ? bus.ls_addr : bus.if_addr;
    // Full-width unsigned compare against 2**MEM_AW: any bit above the RAM index makes it out of range
    assign req_oor_d  = (req_addr_d >> MEM_AW) != ZERO_ADDR;

    // Ready is gated by rst so nothing looks accepted in a cycle that is about to reset
    assign bus.ls_ready = idle & ~rst;
    assign bus.if_ready = idle & ~rst & ~bus.ls_req;

    assign bus.mem_enable = mem_enable_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.if_instr   = if_instr_q;
    assign bus.if_err     = if_err_q;
    assign bus.ls_valid   = ls_valid_q;
    assign bus.ls_rdata   = ls_rdata_q;
    assign bus.ls_err     = ls_err_q;

    // Transaction sequencer: the RAM command is held for ISSUE and CAPTURE, data is taken at the end of CAPTURE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_ls_q     <= 1'b0;
            we_q         <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_rw_q     <= RW_FETCH;
            mem_addr_q   <= ZERO_ADDR;
            mem_din_q    <= ZERO_DATA;
            if_valid_q   <= 1'b0;
            if_instr_q   <= ZERO_DATA;
            if_err_q     <= 1'b0;
            ls_valid_q   <= 1'b0;
            ls_rdata_q   <= ZERO_DATA;
            ls_err_q     <= 1'b0;
        end else begin
            // Valid is a single-cycle pulse; data/err registers keep their last value
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (ls_accept || if_accept) begin
                        src_ls_q <= ls_accept;
                        we_q     <= ls_accept & bus.ls_we;
                        if (req_oor_d) begin
                            // No RAM command for a bad address; answer on the next cycle
                            state_q <= RESP;
                            if (ls_accept) begin
                                ls_valid_q <= 1'b1;
                                ls_err_q   <= 1'b1;
                                ls_rdata_q <= ZERO_DATA;
                            end else begin
                                if_valid_q <= 1'b1;
                                if_err_q   <= 1'b1;
                                if_instr_q <= ZERO_DATA;
                            end
                        end else begin
                            state_q      <= ISSUE;
                            mem_enable_q <= 1'b1;
                            mem_addr_q   <= req_addr_d;
                            if (ls_accept) begin
                                mem_rw_q  <= bus.ls_we ? RW_WRITE : RW_READ;
                                mem_din_q <= bus.ls_we ? bus.ls_wdata : ZERO_DATA;
                            end else begin
                                mem_rw_q  <= RW_FETCH;
                                mem_din_q <= ZERO_DATA;
                            end
                        end
                    end
                end

                ISSUE: begin
                    // Repeat the same command; enable stays up so mem_dout is driven during CAPTURE
                    state_q <= CAPTURE;
                end

                CAPTURE: begin
                    state_q      <= RESP;
                    mem_enable_q <= 1'b0;
                    mem_rw_q     <= RW_FETCH;
                    mem_addr_q   <= ZERO_ADDR;
                    mem_din_q    <= ZERO_DATA;
                    if (src_ls_q) begin
                        ls_valid_q <= 1'b1;
                        ls_err_q   <= 1'b0;
                        ls_rdata_q <= we_q ? ZERO_DATA : bus.mem_dout;
                    end else begin
                        if_valid_q <= 1'b1;
                        if_err_q   <= 1'b0;
                        if_instr_q <= bus.mem_fetch;
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard testbench for mem_access_ctrl

module tb_mem_access_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MEM_AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerrors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: registered read/fetch, write on enable; dout shows garbage when not enabled
    logic [31:0] ram [0:255];
    logic [31:0] dout_reg = 32'h0;
    logic [31:0] fetch_reg = 32'h0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_a = 8'h0;
    logic [31:0] pl_d = 32'h0;

    always @(posedge clk) begin
        if (pl_en) ram[pl_a] <= pl_d;
        if (bus.mem_enable) begin
            case (bus.mem_rw)
                2'b10:   ram[bus.mem_addr[7:0]] <= bus.mem_din;
                2'b01:   dout_reg  <= ram[bus.mem_addr[7:0]];
                2'b00:   fetch_reg <= ram[bus.mem_addr[7:0]];
                default: ;
            endcase
        end
    end
    assign bus.mem_dout  = bus.mem_enable ? dout_reg : 32'hBAD0_BAD0;
    assign bus.mem_fetch = fetch_reg;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          en_cycles;
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] din;
    } exp_t;

    exp_t ls_q[$];
    exp_t if_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: tracks the RAM command between responses and pops the scoreboard on each valid
    int          en_cnt = 0;
    logic        en_stable = 1'b1;
    logic [1:0]  en_rw = 2'b00;
    logic [31:0] en_addr = 32'h0;
    logic [31:0] en_din = 32'h0;

    task automatic check_resp(input bit is_ls);
        exp_t e;
        nchecks++;
        if ((is_ls ? ls_q.size() : if_q.size()) == 0) begin
            nerrors++;
            $display("FAIL %s_unexpected_valid: got valid with empty queue, expected no valid (cycle %0d)",
                     is_ls ? "ls" : "if", cyc);
            return;
        end
        e = is_ls ? ls_q.pop_front() : if_q.pop_front();
        if (is_ls) begin
            chk("ls_rdata", bus.ls_rdata, e.data);
            chk("ls_err", bus.ls_err, e.err);
            chk("ls_cycle", cyc, e.cyc);
        end else begin
            chk("if_instr", bus.if_instr, e.data);
            chk("if_err", bus.if_err, e.err);
            chk("if_cycle", cyc, e.cyc);
        end
        chk("mem_enable_cycles", en_cnt, e.en_cycles);
        if (e.en_cycles != 0) begin
            chk("mem_rw", en_rw, e.rw);
            chk("mem_addr", en_addr, e.addr);
            chk("mem_din", en_din, e.din);
            chk("mem_cmd_stable", en_stable, 1'b1);
        end
        en_cnt    = 0;
        en_stable = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            en_cnt    = 0;
            en_stable = 1'b1;
        end else begin
            if (bus.mem_enable) begin
                if (en_cnt == 0) begin
                    en_rw   = bus.mem_rw;
                    en_addr = bus.mem_addr;
                    en_din  = bus.mem_din;
                end else if (bus.mem_rw !== en_rw || bus.mem_addr !== en_addr || bus.mem_din !== en_din) begin
                    en_stable = 1'b0;
                end
                en_cnt++;
            end
            if (bus.ls_valid && bus.if_valid) chk("one_valid", {bus.ls_valid, bus.if_valid}, 2'b10);
            if (bus.ls_valid) check_resp(1'b1);
            if (bus.if_valid) check_resp(1'b0);
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input logic exp_err, input bit expect_resp,
                            output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.ls_req = 1'b1; bus.ls_we = we; bus.ls_addr = addr; bus.ls_wdata = wdata;
        #1;
        n = 0;
        while (!bus.ls_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("ls_accept", bus.ls_ready, 1'b1);
        acc = cyc;
        if (expect_resp) begin
            e.data      = exp_data;
            e.err       = exp_err;
            e.cyc       = acc + (exp_err ? 1 : 3);
            e.en_cycles = exp_err ? 0 : 2;
            e.rw        = we ? 2'b10 : 2'b01;
            e.addr      = addr;
            e.din       = we ? wdata : 32'h0;
            ls_q.push_back(e);
        end
        @(posedge clk); #1;
        // Scramble the request fields after acceptance; they must have no effect
        bus.ls_req = 1'b0; bus.ls_we = ~we; bus.ls_addr = 32'hFFFF_FFF0; bus.ls_wdata = 32'h5555_AAAA;
    endtask

    task automatic issue_if(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err,
                            output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = addr;
        #1;
        n = 0;
        while (!bus.if_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("if_accept", bus.if_ready, 1'b1);
        acc = cyc;
        e.data      = exp_data;
        e.err       = exp_err;
        e.cyc       = acc + (exp_err ? 1 : 3);
        e.en_cycles = exp_err ? 0 : 2;
        e.rw        = 2'b00;
        e.addr      = addr;
        e.din       = 32'h0;
        if_q.push_back(e);
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.if_addr = 32'hFFFF_FFF0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_ls;
        int a_if;
        int n;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;

        // Reset for two cycles with no requests
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset_ctrl", {bus.if_ready, bus.ls_ready, bus.if_valid, bus.ls_valid,
                           bus.if_err, bus.ls_err, bus.mem_enable, bus.mem_rw}, 64'h0);
        chk("reset_data", {bus.if_instr, bus.ls_rdata}, 64'h0);
        chk("reset_mem", {bus.mem_addr, bus.mem_din}, 64'h0);
        #1 rst = 1'b0;
        #1 chk("ready_after_reset", {bus.if_ready, bus.ls_ready}, 2'b11);

        preload(8'h04, 32'h1234_5678);
        preload(8'hFF, 32'hCAFE_F00D);
        preload(8'h00, 32'h1111_1111);

        // Store then load back, checking the data holds after the pulse
        issue_ls(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, a_ls);
        issue_ls(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a_ls);
        repeat (4) @(negedge clk);
        #1 chk("ls_rdata_hold", {bus.ls_valid, bus.ls_rdata}, {1'b0, 32'hDEAD_BEEF});

        // Fetch
        issue_if(32'h4, 32'h1234_5678, 1'b0, a_if);

        // Same-cycle requests: load/store first, fetch four cycles later
        fork
            issue_ls(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a_ls);
            issue_if(32'h4, 32'h1234_5678, 1'b0, a_if);
        join
        chk("prio_fetch_accept", a_if, a_ls + 4);

        // Range boundary: last word is in range, first word beyond and full-width addresses are not
        issue_ls(1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 1'b1, a_ls);
        issue_ls(1'b0, 32'h0000_FFFF, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, a_ls);
        issue_ls(1'b1, 32'h8000_0000, 32'h7777_7777, 32'h0, 1'b1, 1'b1, a_ls);
        issue_ls(1'b0, 32'h0, 32'h0, 32'h1111_1111, 1'b0, 1'b1, a_ls);
        issue_if(32'hFFFF_FFFF, 32'h0, 1'b1, a_if);

        // Reset during CAPTURE of a load aborts it without a response
        issue_ls(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, a_ls);
        repeat (2) @(negedge clk);
        #1 chk("capture_enable", {bus.mem_enable, bus.mem_rw}, 3'b101);
        #1 rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_outputs", {bus.ls_valid, bus.mem_enable, bus.ls_ready, bus.if_ready}, 4'b0000);
        #1 rst = 1'b0;
        #1 chk("abort_idle_ready", bus.ls_ready, 1'b1);
        issue_ls(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a_ls);

        n = 0;
        while ((ls_q.size() + if_q.size()) != 0 && n < 50) begin
            @(negedge clk); n++;
        end
        repeat (2) @(negedge clk);
        chk("queues_drained", ls_q.size() + if_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the synchronous single-port instruction/data RAM.
- Accepts instruction-fetch requests and load/store requests from the core through req/ready handshakes.
- Arbitrates between them, sequences the RAM's enable/rw/addr/din command, and captures the RAM's dout or fetch register.
- Returns one response per request through a single-cycle valid pulse.

Parameters:
- ADDR_W, 32, width of all address ports.
- DATA_W, 32, width of all data ports.
- MEM_AW, 16, log2 of implemented RAM words; an address >= 2**MEM_AW is out of range.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  instruction fetch request
- if_addr  in  ADDR_W  fetch word address
- if_ready  out  1  fetch request accepted when if_req & if_ready
- if_valid  out  1  one-cycle pulse: if_instr/if_err valid
- if_instr  out  DATA_W  fetched instruction
- if_err  out  1  fetch address out of range
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store word address
- ls_wdata  in  DATA_W  store data
- ls_ready  out  1  load/store accepted when ls_req & ls_ready
- ls_valid  out  1  one-cycle pulse: ls_rdata/ls_err valid (stores acknowledged too)
- ls_rdata  out  DATA_W  load data; 0 on store or error
- ls_err  out  1  load/store address out of range
- mem_enable  out  1  RAM enable
- mem_rw  out  2  01 read, 10 write, 00 fetch
- mem_addr  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read register (tri-stated by RAM when disabled)
- mem_fetch  in  DATA_W  RAM fetch register

Behaviour:
- Reset (rst=1 at an edge): state IDLE; all outputs 0 (mem_rw=00, mem_enable=0, ready=0 during the reset cycle, data outputs 0). Takes priority over everything.
- Reset mid-transaction: the transaction is aborted and no valid pulse is produced. A store whose ISSUE edge has already occurred is committed in RAM; otherwise it is not.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - if_ready = ls_ready = 1; mem_enable = 0.
  - If ls_req=1, accept load/store. Else if if_req=1, accept fetch. Load/store has fixed priority when both are requested in the same cycle; the losing ready is 0 that cycle.
  - Accepted request latches addr, we, wdata, and source. Go to ISSUE, or to RESP with err=1 if the address is out of range (no RAM command issued).
- ISSUE and CAPTURE:
  - Both ready outputs = 0.
  - mem_enable = 1; mem_addr = latched addr.
  - mem_rw = 01 for load, 10 for store, 00 for fetch.
  - mem_din = latched wdata for a store, else 0.
  - Command is held identical for both cycles. This is idempotent: a store rewrites the same word; a read or fetch reloads the same value. Enable stays high so mem_dout is never tri-stated while it is being sampled.
  - At the end of CAPTURE, latch mem_dout (load) or mem_fetch (fetch) into the response register, then go to RESP.
- RESP:
  - mem_enable = 0.
  - Exactly one of if_valid / ls_valid = 1 for this cycle.
  - Data and err outputs are set; ls_rdata = 0 for a store or error; if_instr = 0 on error.
  - Go to IDLE.
- Data and err outputs hold their value after the valid pulse until the next response from the same source.
- Latency: accept edge at cycle 0, then ISSUE in cycle 1, CAPTURE in cycle 2, valid in cycle 3. Out-of-range responses are valid in cycle 1.
- Throughput: one transaction per 4 cycles (per 2 cycles for errors).
- Request signals may deassert after acceptance with no effect. Requests arriving outside IDLE are ignored until IDLE; the requester must hold req.
- Address range check compares the full ADDR_W address against 2**MEM_AW, unsigned.
- No ports other than the mem_* ports touch RAM.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all req=0 -> all outputs 0 and mem_enable=0 throughout; after release, if_ready=ls_ready=1.
- Store then load: store 0xDEADBEEF to addr 0x10 -> mem_rw=10, mem_enable=1 for exactly 2 cycles, ls_valid in cycle 3 with ls_rdata=0. Then load 0x10 -> mem_rw=01, ls_rdata=0xDEADBEEF in cycle 3.
- Fetch: preload addr 0x4 = 0x12345678; if_req with addr 0x4 -> mem_rw=00, if_valid exactly one cycle at accept+3, if_instr=0x12345678, if_err=0.
- Simultaneous requests: if_req and ls_req (load 0x10) high in the same IDLE cycle -> load served first (ls_valid at +3), then fetch accepted at +4 (if_valid at +7).
- Out-of-range: ls load addr 0x00010000 -> no mem_enable pulse, ls_valid at +1 with ls_err=1 and ls_rdata=0.
- Reset mid-op: rst asserted during CAPTURE of a load -> no ls_valid, state IDLE, mem_enable=0 the next cycle; a following load of the same address completes normally.
